// File: rtl/exec_arbiter_pkg.sv
// Shared definitions for the execution-unit arbiter.
//   LEN_CONTEXT : width of the branch context mask
//   state_e     : arbiter FSM states (2-bit encoding)
//   ctx_match   : squash test of a context mask against the active hazard
package exec_arbiter_pkg;

  localparam int unsigned LEN_CONTEXT = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // High when a hazard is flagged and it names at least one context in ctx.
  function automatic logic ctx_match(input logic                   hazard,
                                     input logic [LEN_CONTEXT-1:0] info,
                                     input logic [LEN_CONTEXT-1:0] ctx);
    return hazard & (|(info & ctx));
  endfunction

endpackage

// File: rtl/exec_arbiter_rr_select.sv
// rr_select: pick one eligible requester, searching upward from ptr and
// wrapping N_REQ-1 -> 0. With ptr tied to 0 this is lowest-index priority.
//   eligible : requesters allowed to win this cycle
//   ptr      : index where the search starts
//   grant    : one-hot winner, zero when nothing is eligible
module rr_select #(
  parameter int N_REQ  = 4,
  parameter int LEN_ID = 2
) (
  input  logic [N_REQ-1:0]  eligible,
  input  logic [LEN_ID-1:0] ptr,
  output logic [N_REQ-1:0]  grant
);

  int unsigned idx;
  logic        found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = (32'(ptr) + 32'(off)) % 32'(N_REQ);
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exec_arbiter.sv
// exec_arbiter: shares one execution unit among N_REQ issue slots.
// An eligible requester is granted from IDLE, the op runs until u_done, and
// the result is released in DONE unless a branch hazard squashed its context.
// Build option: define EXEC_ARB_RR_EN for round-robin selection; otherwise
// lowest eligible index wins.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   req, req_context    : ready requests and per-requester context masks
//   grant, u_start      : accept pulse to the requester / start to the unit
//   u_id, u_done        : index of op in flight / completion from the unit
//   branch_hazard,
//   hazard_context_info : flush request and contexts to squash
//   res_valid, res_id   : commit pulse and its requester index
//   busy                : arbiter not idle
module exec_arbiter
  import exec_arbiter_pkg::*;
#(
  parameter  int N_REQ  = 4,
  localparam int LEN_ID = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*LEN_CONTEXT-1:0] req_context,
  output logic [N_REQ-1:0]             grant,
  output logic                         u_start,
  output logic [LEN_ID-1:0]            u_id,
  input  logic                         u_done,
  input  logic                         branch_hazard,
  input  logic [LEN_CONTEXT-1:0]       hazard_context_info,
  output logic                         res_valid,
  output logic [LEN_ID-1:0]            res_id,
  output logic                         busy
);

  state_e                 state_q;
  logic [LEN_ID-1:0]      u_id_q;
  logic [LEN_CONTEXT-1:0] cur_ctx_q;
  logic                   kill_q;
  logic [LEN_ID-1:0]      ptr;
  logic [N_REQ-1:0]       eligible;
  logic [N_REQ-1:0]       sel;
  logic [LEN_ID-1:0]      sel_id;
  logic                   cur_match;
  logic                   idle;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req[i] & ~ctx_match(branch_hazard, hazard_context_info,
                                        req_context[i*LEN_CONTEXT +: LEN_CONTEXT]);
    end
  end

`ifdef EXEC_ARB_RR_EN
  logic [LEN_ID-1:0] ptr_q;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  rr_select #(
    .N_REQ  (N_REQ),
    .LEN_ID (LEN_ID)
  ) u_rr_select (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (sel)
  );

  always_comb begin
    sel_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel[i]) sel_id = LEN_ID'(i);
    end
  end

  assign cur_match = ctx_match(branch_hazard, hazard_context_info, cur_ctx_q);
  // Gated by rst so nothing is granted while reset is held.
  assign idle      = (state_q == StIdle) & ~rst;
  assign grant     = idle ? sel : '0;
  assign u_start   = idle & (|eligible);
  // A hazard arriving in DONE still squashes the result.
  assign res_valid = (state_q == StDone) & ~kill_q & ~cur_match;
  assign u_id      = u_id_q;
  assign res_id    = u_id_q;
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      u_id_q    <= '0;
      cur_ctx_q <= '0;
      kill_q    <= 1'b0;
`ifdef EXEC_ARB_RR_EN
      ptr_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (u_start) begin
            state_q   <= StRun;
            u_id_q    <= sel_id;
            cur_ctx_q <= req_context[sel_id*LEN_CONTEXT +: LEN_CONTEXT];
            kill_q    <= 1'b0;
`ifdef EXEC_ARB_RR_EN
            ptr_q     <= (sel_id == LEN_ID'(N_REQ - 1)) ? '0 : sel_id + LEN_ID'(1);
`endif
          end
        end
        StRun: begin
          if (cur_match) kill_q <= 1'b1;
          if (u_done) state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_arbiter.sv
module tb_exec_arbiter;
  import exec_arbiter_pkg::*;

  localparam int NR = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NR-1:0]             req;
  logic [NR*LEN_CONTEXT-1:0] req_context;
  logic [NR-1:0]             grant;
  logic                      u_start;
  logic [1:0]                u_id;
  logic                      u_done;
  logic                      branch_hazard;
  logic [LEN_CONTEXT-1:0]    hazard_context_info;
  logic                      res_valid;
  logic [1:0]                res_id;
  logic                      busy;

  typedef struct packed {
    logic       valid;
    logic [1:0] id;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  exec_arbiter #(.N_REQ(NR)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req                 (req),
    .req_context         (req_context),
    .grant               (grant),
    .u_start             (u_start),
    .u_id                (u_id),
    .u_done              (u_done),
    .branch_hazard       (branch_hazard),
    .hazard_context_info (hazard_context_info),
    .res_valid           (res_valid),
    .res_id              (res_id),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " grant"}, 32'(grant), 32'h0);
    check({tag, " u_start"}, 32'(u_start), 32'h0);
    check({tag, " res_valid"}, 32'(res_valid), 32'h0);
    check({tag, " busy"}, 32'(busy), 32'h0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    check_quiet(tag);
    check({tag, " u_id"}, 32'(u_id), 32'h0);
    next_cycle();
    rst = 1'b0;
  endtask

  // One full transaction: grant cycle, run_cycles RUN cycles (u_done in the
  // last), then the DONE cycle. Hazards: haz_idle in the grant cycle, haz_run
  // in the first RUN cycle only, haz_done in DONE. A zero info means no hazard.
  task automatic run_op(input string tag, input logic [3:0] req_v, input logic [15:0] ctx_v,
                        input logic [3:0] haz_idle, input logic [3:0] haz_run,
                        input logic [3:0] haz_done, input int run_cycles,
                        input logic [3:0] exp_grant, input logic exp_valid);
    exp_t e;
    exp_t got;
    e.valid = exp_valid;
    e.id    = 2'd0;
    for (int i = 0; i < NR; i++) if (exp_grant[i]) e.id = 2'(i);
    sb.push_back(e);

    req                 = req_v;
    req_context         = ctx_v;
    branch_hazard       = (haz_idle != 4'b0);
    hazard_context_info = haz_idle;
    u_done              = 1'b0;
    @(negedge clk);
    check({tag, " grant"}, 32'(grant), 32'(exp_grant));
    check({tag, " u_start"}, 32'(u_start), 32'h1);
    check({tag, " idle busy"}, 32'(busy), 32'h0);
    next_cycle();

    for (int r = 0; r < run_cycles; r++) begin
      branch_hazard       = (r == 0) && (haz_run != 4'b0);
      hazard_context_info = haz_run;
      u_done              = (r == run_cycles - 1);
      @(negedge clk);
      check({tag, " run busy"}, 32'(busy), 32'h1);
      check({tag, " run grant"}, 32'(grant), 32'h0);
      check({tag, " run u_start"}, 32'(u_start), 32'h0);
      check({tag, " run u_id"}, 32'(u_id), 32'(e.id));
      check({tag, " run res_valid"}, 32'(res_valid), 32'h0);
      next_cycle();
    end

    u_done              = 1'b0;
    branch_hazard       = (haz_done != 4'b0);
    hazard_context_info = haz_done;
    @(negedge clk);
    got = sb.pop_front();
    check({tag, " done busy"}, 32'(busy), 32'h1);
    check({tag, " done grant"}, 32'(grant), 32'h0);
    check({tag, " res_valid"}, 32'(res_valid), 32'(got.valid));
    if (got.valid) check({tag, " res_id"}, 32'(res_id), 32'(got.id));
    next_cycle();
    branch_hazard       = 1'b0;
    hazard_context_info = '0;
  endtask

  initial begin
    logic [3:0] rr_seq [5];
    rst                 = 1'b1;
    req                 = 4'b1111;
    req_context         = 16'hffff;
    u_done              = 1'b0;
    branch_hazard       = 1'b0;
    hazard_context_info = '0;

    // Reset with requests pending: nothing may be granted.
    do_reset("reset");
    req = '0;

    // Basic issue, three RUN cycles: busy over RUN x3 + DONE.
    run_op("basic", 4'b0110, 16'h4321, 4'h0, 4'h0, 4'h0, 3, 4'b0010, 1'b1);
    @(negedge clk);
    check("basic back to idle", 32'(busy), 32'h0);
    next_cycle();

    // Back-to-back issue with all requests held.
    do_reset("reset2");
`ifdef EXEC_ARB_RR_EN
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    rr_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    for (int k = 0; k < 5; k++) begin
      run_op($sformatf("seq%0d", k), 4'b1111, 16'h8421, 4'h0, 4'h0, 4'h0, 1, rr_seq[k], 1'b1);
    end

    // Squash during RUN: kill must stick until DONE.
    run_op("squash run", 4'b0010, 16'h0020, 4'h0, 4'b0011, 4'h0, 2, 4'b0010, 1'b0);
    // Hazard coincides with u_done.
    run_op("squash at done", 4'b0010, 16'h0020, 4'h0, 4'b0011, 4'h0, 1, 4'b0010, 1'b0);
    // Hazard during the DONE cycle itself.
    run_op("squash in done", 4'b0010, 16'h0020, 4'h0, 4'h0, 4'b0010, 1, 4'b0010, 1'b0);
    // Non-matching hazard leaves the result alone.
    run_op("no match", 4'b0010, 16'h0040, 4'h0, 4'b0011, 4'b0011, 2, 4'b0010, 1'b1);

    // Hazard masks requester 0 in IDLE; requester 2 wins.
    do_reset("reset3");
    run_op("idle mask", 4'b0101, 16'h0401, 4'b0001, 4'h0, 4'h0, 1, 4'b0100, 1'b1);

    // Every request masked: stay idle.
    req                 = 4'b0001;
    req_context         = 16'h0001;
    branch_hazard       = 1'b1;
    hazard_context_info = 4'b0001;
    @(negedge clk);
    check_quiet("all masked");
    next_cycle();
    branch_hazard = 1'b0;
    req           = '0;
    @(negedge clk);
    check("all masked stays idle", 32'(busy), 32'h0);
    next_cycle();

    // Reset in RUN, then a stale u_done.
    req         = 4'b0001;
    req_context = 16'h0001;
    @(negedge clk);
    check("pre-reset grant", 32'(grant), 32'h1);
    next_cycle();
    req = '0;
    @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'h1);
    next_cycle();
    do_reset("mid-run reset");
    u_done = 1'b1;
    @(negedge clk);
    check_quiet("stale u_done");
    next_cycle();
    u_done = 1'b0;
    @(negedge clk);
    check_quiet("after stale u_done");
    next_cycle();

    // u_done while idle with no requests.
    u_done = 1'b1;
    @(negedge clk);
    check_quiet("idle u_done");
    next_cycle();
    u_done = 1'b0;
    @(negedge clk);
    check_quiet("idle u_done after");
    check("scoreboard drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
